// File: rtl/memory_pkg.sv
// Shared types and defaults for the memory responder.
// State and op encodings used by the FSM and datapath.
package memory_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_FAULT = 2'd2
   } op_t;

   localparam int DEF_ADDR_BITS   = 9;
   localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/word_ram.sv
// Word-addressed 32-bit RAM, synchronous write and read.
// Read data holds until the next enabled read.
module word_ram
   import memory_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] r_mem [2**ADDR_BITS];
   logic [31:0] r_rdata;

   // Single-port access; contents are never cleared
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
      if (re) r_rdata <= r_mem[addr];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR interface.
// Latches a request, waits WAIT_CYCLES, then completes it.
module memory_responder
   import memory_pkg::*;
#(
   parameter int ADDR_BITS   = DEF_ADDR_BITS,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] Maddress_in,
   input  logic [31:0] Mdata_in,
   output logic [31:0] Mdata_out,
   output logic        mem_ready,
   output logic        mem_busy,
   output logic        mem_fault
);

   state_t      r_state;
   state_t      w_next;
   op_t         r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_cnt;
   logic        r_rd_sel;
   logic        r_ready;
   logic        r_busy;
   logic        r_fault;
   logic        w_accept;
   logic        w_done_entry;
   logic        w_addr_hi;
   logic        w_fault;
   logic        w_ram_we;
   logic        w_ram_re;
   logic [31:0] w_rdata;

   generate
      if (ADDR_BITS < 32) begin : g_hi
         assign w_addr_hi = |r_addr[31:ADDR_BITS];
      end else begin : g_nohi
         assign w_addr_hi = 1'b0;
      end
   endgenerate

   assign w_fault = (r_op == OP_FAULT) | w_addr_hi;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and RAM strobes, which fire only on DONE entry
   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_done_entry = 1'b0;
      w_ram_we     = 1'b0;
      w_ram_re     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (mem_read | mem_write) begin
               w_accept = 1'b1;
               w_next   = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == 4'd0) begin
               w_next       = DONE;
               w_done_entry = 1'b1;
               w_ram_we     = (r_op == OP_WRITE) & ~w_fault;
               w_ram_re     = (r_op == OP_READ) & ~w_fault;
            end
         end
         DONE: w_next = RELEASE;
         RELEASE: begin
            if (!mem_read && !mem_write) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Request latches, wait counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= OP_READ;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_cnt    <= '0;
         r_rd_sel <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (mem_read && mem_write) r_op <= OP_FAULT;
            else if (mem_write)        r_op <= OP_WRITE;
            else                       r_op <= OP_READ;
            r_addr  <= Maddress_in;
            r_wdata <= Mdata_in;
            r_cnt   <= 4'(WAIT_CYCLES);
         end else if (r_state == BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // A clean write leaves the last read value on Mdata_out
         if (w_done_entry && !(r_op == OP_WRITE && !w_fault))
            r_rd_sel <= ~w_fault;
         r_ready <= w_done_entry;
         r_fault <= w_done_entry & w_fault;
         r_busy  <= (w_next == BUSY) | (w_next == DONE);
      end
   end

   word_ram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk  (clk),
      .we   (w_ram_we),
      .re   (w_ram_re),
      .addr (r_addr[ADDR_BITS-1:0]),
      .wdata(r_wdata),
      .rdata(w_rdata)
   );

   assign Mdata_out = r_rd_sel ? w_rdata : 32'd0;
   assign mem_ready = r_ready;
   assign mem_busy  = r_busy;
   assign mem_fault = r_fault;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (ADDR_BITS=9, WAIT_CYCLES=2).
// Table of accesses plus strobe-hold and reset-abort sequences.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] Maddress_in = '0;
   logic [31:0] Mdata_in = '0;
   logic [31:0] Mdata_out;
   logic        mem_ready;
   logic        mem_busy;
   logic        mem_fault;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        flt;
      logic        chk_d;
      logic [31:0] dat;
   } vec_t;

   vec_t        vt[11];
   logic [31:0] exp_out;
   int          lat;
   int          bz;
   logic        rf;
   logic [31:0] rd_val;

   memory_responder #(
      .ADDR_BITS(9),
      .WAIT_CYCLES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .Maddress_in(Maddress_in),
      .Mdata_in(Mdata_in),
      .Mdata_out(Mdata_out),
      .mem_ready(mem_ready),
      .mem_busy(mem_busy),
      .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h", nm, act, exp);
      else
         n_pass++;
   endtask

   // Drive a request and hold it until mem_ready (bounded)
   task automatic access(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int l, output int b,
                         output logic f, output logic [31:0] q);
      @(negedge clk);
      mem_read    = rd;
      mem_write   = wr;
      Maddress_in = a;
      Mdata_in    = d;
      l = 0;
      b = 0;
      do begin
         @(posedge clk);
         #1;
         l++;
         if (mem_busy) b++;
      end while (!mem_ready && l < 20);
      f = mem_fault;
      q = Mdata_out;
   endtask

   // Pulse must be one cycle; then drop strobes and let it idle
   task automatic finish_access(input string nm);
      @(posedge clk);
      #1;
      chk({nm, "_ready_pulse"}, {31'd0, mem_ready}, 32'd0);
      chk({nm, "_busy_off"}, {31'd0, mem_busy}, 32'd0);
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      vt[0]  = '{1'b0, 1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 1'b0, 32'd5,         32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      vt[2]  = '{1'b0, 1'b1, 32'd3,         32'h33333333, 1'b0, 1'b0, 32'h0};
      vt[3]  = '{1'b1, 1'b1, 32'd3,         32'hBAD0BAD0, 1'b1, 1'b1, 32'h0};
      vt[4]  = '{1'b1, 1'b0, 32'd3,         32'h0,        1'b0, 1'b1, 32'h33333333};
      vt[5]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        1'b1, 1'b1, 32'h0};
      vt[6]  = '{1'b0, 1'b1, 32'h1FF,       32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
      vt[7]  = '{1'b1, 1'b0, 32'h1FF,       32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
      vt[8]  = '{1'b0, 1'b1, 32'h8000_0005, 32'h00000001, 1'b1, 1'b1, 32'h0};
      vt[9]  = '{1'b1, 1'b0, 32'd5,         32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      vt[10] = '{1'b0, 1'b1, 32'd7,         32'h77777777, 1'b0, 1'b0, 32'h0};

      // Reset state
      @(negedge clk);
      chk("rst_data", Mdata_out, 32'd0);
      chk("rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_busy", {31'd0, mem_busy}, 32'd0);
      chk("rst_fault", {31'd0, mem_fault}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_out = 32'd0;

      // Table-driven accesses
      for (int i = 0; i < 11; i++) begin
         access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata,
                lat, bz, rf, rd_val);
         chk($sformatf("v%0d_latency", i), lat, 4);
         chk($sformatf("v%0d_busy", i), bz, 4);
         chk($sformatf("v%0d_fault", i), {31'd0, rf}, {31'd0, vt[i].flt});
         if (vt[i].chk_d) begin
            chk($sformatf("v%0d_data", i), rd_val, vt[i].dat);
            exp_out = vt[i].dat;
         end
         finish_access($sformatf("v%0d", i));
         chk($sformatf("v%0d_hold", i), Mdata_out, exp_out);
      end

      // Strobe held after completion: no second access
      access(1'b1, 1'b0, 32'd5, 32'h0, lat, bz, rf, rd_val);
      chk("hold_latency", lat, 4);
      chk("hold_data", rd_val, 32'hDEADBEEF);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold_noready%0d", k), {31'd0, mem_ready}, 32'd0);
         chk($sformatf("hold_nobusy%0d", k), {31'd0, mem_busy}, 32'd0);
      end
      @(negedge clk);
      mem_read = 1'b0;
      @(posedge clk);
      access(1'b1, 1'b0, 32'd3, 32'h0, lat, bz, rf, rd_val);
      chk("reaccept_latency", lat, 4);
      chk("reaccept_data", rd_val, 32'h33333333);
      finish_access("reaccept");

      // Reset one cycle into a write aborts it
      @(negedge clk);
      mem_write   = 1'b1;
      Maddress_in = 32'd7;
      Mdata_in    = 32'h12345678;
      @(posedge clk);
      #1;
      chk("abort_busy_before", {31'd0, mem_busy}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_data", Mdata_out, 32'd0);
      chk("abort_ready", {31'd0, mem_ready}, 32'd0);
      chk("abort_busy", {31'd0, mem_busy}, 32'd0);
      chk("abort_fault", {31'd0, mem_fault}, 32'd0);
      @(negedge clk);
      mem_write = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      access(1'b1, 1'b0, 32'd7, 32'h0, lat, bz, rf, rd_val);
      chk("after_abort_latency", lat, 4);
      chk("after_abort_data", rd_val, 32'h77777777);
      finish_access("after_abort");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
